led_pattern_gen: RTL and testbench

Parametrised LED pattern generator that succeeds the fixed 4-LED one-hot chaser. It drives N_LED outputs from a programmable step timer. It supports four runtime-selectable patterns, a speed prescaler and an enable/pause input. It sits between the board clock/reset and the LED pins and needs no host interface beyond static control inputs.

---
 rtl/led_pattern_gen_if.sv | 23 ++
 rtl/led_pattern_gen.sv | 107 ++++++++++
 tb/tb_led_pattern_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle for led_pattern_gen.
// en/mode/speed are static levels from the controller; step_o is a one-cycle strobe with no back-pressure.
interface led_pattern_gen_if #(
  parameter int N_LED = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic [N_LED-1:0] led_data;
  logic             step_o;
  logic [1:0]       dbg_mode;
  logic             dbg_dir;

  modport master (
    output en, mode, speed,
    input  led_data, step_o, dbg_mode, dbg_dir
  );

  modport slave (
    input  en, mode, speed,
    output led_data, step_o, dbg_mode, dbg_dir
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator: base tick timer, 2^speed prescaler and
// four patterns (rotate-left, rotate-right, bounce, blink-all).
module led_pattern_gen #(
  parameter int              N_LED       = 4,
  parameter longint unsigned TICK_CYCLES = 200000000
) (
  input logic              clk,
  input logic              rstn,
  led_pattern_gen_if.slave bus
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {ROT_L = 2'd0, ROT_R = 2'd1, BOUNCE = 2'd2, BLINK = 2'd3} mode_t;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [CW-1:0]    cnt;
  logic [2:0]       pre;
  logic [2:0]       limit;
  mode_t            cur_mode;
  dir_t             dir;
  logic [N_LED-1:0] led;
  logic             step_r;

  logic             tick;
  mode_t            req_mode;
  logic [N_LED-1:0] next_led;
  dir_t             next_dir;

  assign tick     = (cnt == TERM);
  assign req_mode = mode_t'(bus.mode);

  always_comb begin
    limit = 3'd0;
    case (bus.speed)
      2'd0: limit = 3'd0;
      2'd1: limit = 3'd1;
      2'd2: limit = 3'd3;
      default: limit = 3'd7;
    endcase
  end

  // Pattern to show on the next step; a mode change always reloads a clean start pattern.
  always_comb begin
    next_led = led;
    next_dir = dir;
    if (req_mode != cur_mode) begin
      next_dir = UP;
      case (req_mode)
        ROT_L:   next_led = {{(N_LED-1){1'b0}}, 1'b1};
        ROT_R:   next_led = {1'b1, {(N_LED-1){1'b0}}};
        BOUNCE:  next_led = {{(N_LED-1){1'b0}}, 1'b1};
        default: next_led = '1;
      endcase
    end else begin
      case (cur_mode)
        ROT_L:   next_led = {led[N_LED-2:0], led[N_LED-1]};
        ROT_R:   next_led = {led[0], led[N_LED-1:1]};
        BOUNCE: begin
          if (dir == UP) begin
            next_led = {led[N_LED-2:0], 1'b0};
            next_dir = led[N_LED-2] ? DOWN : UP;
          end else begin
            next_led = {1'b0, led[N_LED-1:1]};
            next_dir = led[1] ? UP : DOWN;
          end
        end
        default: next_led = ~led;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      pre      <= 3'd0;
      cur_mode <= ROT_L;
      dir      <= UP;
      led      <= {{(N_LED-1){1'b0}}, 1'b1};
      step_r   <= 1'b0;
    end else begin
      step_r <= 1'b0;
      if (bus.en) begin
        if (tick) begin
          cnt <= '0;
          // >= so that lowering speed mid-count steps on the very next tick.
          if (pre >= limit) begin
            pre      <= 3'd0;
            step_r   <= 1'b1;
            cur_mode <= req_mode;
            dir      <= next_dir;
            led      <= next_led;
          end else begin
            pre <= pre + 3'd1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.led_data = led;
  assign bus.step_o   = step_r;
  assign bus.dbg_mode = cur_mode;
  assign bus.dbg_dir  = dir;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-LED/4-cycle instance and an 8-LED/2-cycle instance.
module tb_led_pattern_gen;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  led_pattern_gen_if #(.N_LED(4)) ifa ();
  led_pattern_gen_if #(.N_LED(8)) ifb ();

  led_pattern_gen #(.N_LED(4), .TICK_CYCLES(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  led_pattern_gen #(.N_LED(8), .TICK_CYCLES(2)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next step pulse, then checks its spacing and the LED value.
  task automatic step_chk(input bit sel, input int exp_cyc, input logic [31:0] exp_led,
                          input string tag);
    int   cyc;
    logic s;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      s = sel ? ifb.step_o : ifa.step_o;
    end while (!s && cyc < 40);
    chk({tag, "_period"}, cyc, exp_cyc);
    chk({tag, "_led"}, sel ? 32'(ifb.led_data) : 32'(ifa.led_data), exp_led);
  endtask

  initial begin
    logic seen;
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    ifa.en = 1'b1; ifa.mode = 2'd0; ifa.speed = 2'd0;
    ifb.en = 1'b0; ifb.mode = 2'd1; ifb.speed = 2'd0;

    repeat (2) @(negedge clk);
    chk("reset_led_a", 32'(ifa.led_data), 32'h1);
    chk("reset_step_a", 32'(ifa.step_o), 32'h0);
    chk("reset_mode_a", 32'(ifa.dbg_mode), 32'h0);
    chk("reset_led_b", 32'(ifb.led_data), 32'h1);
    rstn = 1'b1;

    // Rotate-left
    step_chk(0, 4, 32'h2, "rotl1");
    step_chk(0, 4, 32'h4, "rotl2");
    step_chk(0, 4, 32'h8, "rotl3");
    step_chk(0, 4, 32'h1, "rotl4");

    // Bounce
    ifa.mode = 2'd2;
    step_chk(0, 4, 32'h1, "bnc_load");
    chk("bnc_mode", 32'(ifa.dbg_mode), 32'h2);
    step_chk(0, 4, 32'h2, "bnc1");
    step_chk(0, 4, 32'h4, "bnc2");
    step_chk(0, 4, 32'h8, "bnc3");
    chk("bnc_dir_down", 32'(ifa.dbg_dir), 32'h1);
    step_chk(0, 4, 32'h4, "bnc4");
    step_chk(0, 4, 32'h2, "bnc5");
    step_chk(0, 4, 32'h1, "bnc6");
    step_chk(0, 4, 32'h2, "bnc7");

    // Mode change mid-interval into blink, then rotate-right
    repeat (2) @(negedge clk);
    ifa.mode = 2'd3;
    step_chk(0, 2, 32'hF, "blink_load");
    step_chk(0, 4, 32'h0, "blink1");
    step_chk(0, 4, 32'hF, "blink2");
    ifa.mode = 2'd1;
    step_chk(0, 4, 32'h8, "rotr_load");
    step_chk(0, 4, 32'h4, "rotr1");

    // Speed 2 and pause
    ifa.speed = 2'd2;
    step_chk(0, 16, 32'h2, "spd1");
    step_chk(0, 16, 32'h1, "spd2");
    repeat (5) @(negedge clk);
    ifa.en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | ifa.step_o;
    end
    chk("pause_led", 32'(ifa.led_data), 32'h1);
    chk("pause_nostep", 32'(seen), 32'h0);
    ifa.en = 1'b1;
    step_chk(0, 11, 32'h8, "pause_resume");
    chk("b_held_led", 32'(ifb.led_data), 32'h1);

    // Async reset while showing 0100
    ifa.speed = 2'd0;
    step_chk(0, 4, 32'h4, "pre_rst");
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_led", 32'(ifa.led_data), 32'h1);
    chk("async_rst_step", 32'(ifa.step_o), 32'h0);
    ifa.mode = 2'd0;
    #1 rstn = 1'b1;
    step_chk(0, 4, 32'h2, "post_rst");

    // 8 LEDs, 2-cycle tick, rotate-right
    ifb.en = 1'b1;
    step_chk(1, 2, 32'h80, "w8_load");
    step_chk(1, 2, 32'h40, "w8_1");
    step_chk(1, 2, 32'h20, "w8_2");
    step_chk(1, 2, 32'h10, "w8_3");
    step_chk(1, 2, 32'h08, "w8_4");
    step_chk(1, 2, 32'h04, "w8_5");
    step_chk(1, 2, 32'h02, "w8_6");
    step_chk(1, 2, 32'h01, "w8_7");
    step_chk(1, 2, 32'h80, "w8_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
